// File: rtl/multi_channel_ramp_adc.sv
// -----------------------------------------------------------------------------
// multi_channel_ramp_adc
//
// Single-slope (ramp-compare) ADC controller. CHANNELS external comparators are
// measured in parallel against one shared digital ramp. An internal FSM
// sequences capacitor discharge/settle, the ramp count and result latching.
//
// Ports:
//   clk             system clock, all logic on the rising edge
//   reset           synchronous, active-high reset
//   start           request one conversion sweep (sampled only in IDLE)
//   continuous      1 = re-arm automatically after each sweep
//   compared_value  asynchronous comparator outputs, 1 = ramp still below input
//   ramp_out        current ramp count, drives the PWM/DAC
//   discharge       1 = hold the ramp capacitor discharged
//   busy            high in every state except IDLE
//   valid           one-cycle strobe, data/overflow just updated
//   data            results, channel i at bits [i*WIDTH +: WIDTH]
//   overflow        per-channel over-range flag of the last sweep
// -----------------------------------------------------------------------------
module multi_channel_ramp_adc #(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 3,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      continuous,
    input  logic [CHANNELS-1:0]       compared_value,
    output logic [WIDTH-1:0]          ramp_out,
    output logic                      discharge,
    output logic                      busy,
    output logic                      valid,
    output logic [CHANNELS*WIDTH-1:0] data,
    output logic [CHANNELS-1:0]       overflow
);

    localparam logic [WIDTH-1:0] FULL_SCALE  = '1;
    localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RAMP,
        DONE
    } state_t;

    state_t                      state;
    state_t                      state_next;

    logic [CHANNELS-1:0]         sync_ff;
    logic [CHANNELS-1:0]         sync_cv;
    logic [15:0]                 settle_cnt;
    logic [WIDTH-1:0]            ramp_cnt;
    logic [CHANNELS-1:0]         flag;
    logic [CHANNELS*WIDTH-1:0]   shadow;

    logic [CHANNELS-1:0]         capture;
    logic [CHANNELS-1:0]         flag_next;
    logic                        sweep_end;
    logic [CHANNELS*WIDTH-1:0]   data_next;

    // Comparator synchroniser. Resets to 1 ("ramp still below input") so a
    // reset can never fake a capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= '1;
            sync_cv <= '1;
        end else begin
            sync_ff <= compared_value;
            sync_cv <= sync_ff;
        end
    end

    // Capture decode. A channel captures only once per sweep: the first RAMP
    // cycle in which its synchronised comparator reads 0.
    always_comb begin
        capture   = '0;
        flag_next = flag;
        sweep_end = 1'b0;
        data_next = '0;
        if (state == RAMP) begin
            capture   = ~flag & ~sync_cv;
            flag_next = flag | capture;
            sweep_end = (&flag_next) || (ramp_cnt == FULL_SCALE);
        end
        // Result for the sweep that ends this cycle: a capture made in this
        // very cycle takes the live ramp count, since shadow is not yet written.
        for (int i = 0; i < CHANNELS; i++) begin
            if (capture[i]) begin
                data_next[i*WIDTH +: WIDTH] = ramp_cnt;
            end else if (flag[i]) begin
                data_next[i*WIDTH +: WIDTH] = shadow[i*WIDTH +: WIDTH];
            end else begin
                data_next[i*WIDTH +: WIDTH] = FULL_SCALE;
            end
        end
    end

    // FSM next state and outputs.
    always_comb begin
        state_next = state;
        ramp_out   = '0;
        discharge  = 1'b1;
        busy       = 1'b1;
        valid      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start || continuous) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = RAMP;
                end
            end
            RAMP: begin
                discharge = 1'b0;
                ramp_out  = ramp_cnt;
                if (sweep_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid      = 1'b1;
                state_next = continuous ? SETTLE : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counters, capture flags and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            ramp_cnt   <= '0;
            flag       <= '0;
            shadow     <= '0;
            data       <= '0;
            overflow   <= '0;
        end else begin
            state <= state_next;

            settle_cnt <= (state == SETTLE) ? settle_cnt + 16'd1 : 16'd0;

            // Counting stops on the last RAMP cycle, so the ramp never wraps.
            ramp_cnt <= (state == RAMP && !sweep_end) ? ramp_cnt + WIDTH'(1) : '0;

            if (state == SETTLE) begin
                flag <= '0;
            end else begin
                flag <= flag_next;
            end

            for (int i = 0; i < CHANNELS; i++) begin
                if (capture[i]) begin
                    shadow[i*WIDTH +: WIDTH] <= ramp_cnt;
                end
            end

            // Results are written on the edge into DONE so they are already
            // presented while valid is high.
            if (sweep_end) begin
                data     <= data_next;
                overflow <= ~flag_next;
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_ramp_adc.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_ramp_adc
//
// Scoreboard bench for multi_channel_ramp_adc (WIDTH=8, CHANNELS=3,
// SETTLE_CYCLES=4). Stimulus pushes the expected result of each sweep into a
// queue; a monitor pops and compares whenever valid is seen.
// -----------------------------------------------------------------------------
module tb_multi_channel_ramp_adc;

    localparam int W = 8;
    localparam int C = 3;
    localparam int S = 4;

    typedef struct packed {
        logic [C*W-1:0] d;
        logic [C-1:0]   ov;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           continuous;
    logic [C-1:0]   cv;
    logic [W-1:0]   ramp_out;
    logic           discharge;
    logic           busy;
    logic           valid;
    logic [C*W-1:0] data;
    logic [C-1:0]   overflow;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    multi_channel_ramp_adc #(
        .WIDTH        (W),
        .CHANNELS     (C),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .continuous    (continuous),
        .compared_value(cv),
        .ramp_out      (ramp_out),
        .discharge     (discharge),
        .busy          (busy),
        .valid         (valid),
        .data          (data),
        .overflow      (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every valid strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: data=0x%0h overflow=%b, no result expected", data, overflow);
            end else begin
                mon_e = q.pop_front();
                check("valid_data", 32'(data), 32'(mon_e.d));
                check("valid_overflow", 32'(overflow), 32'(mon_e.ov));
            end
        end
    end

    // One sweep started by a start pulse. thN = ramp value during which
    // channel N's comparator falls (-1 = never). pulse_k / pulse_ramp pulse
    // start again during the sweep; glitch_ramp returns ch0 to 1.
    task automatic run_sweep(input int th0, input int th1, input int th2,
                             input logic [C*W-1:0] ed, input logic [C-1:0] eo,
                             input int pulse_k, input int pulse_ramp, input int glitch_ramp,
                             output int first_k, output int n_ramp, output int last_ramp);
        exp_t e;
        logic done;
        e.d       = ed;
        e.ov      = eo;
        q.push_back(e);
        first_k   = -1;
        n_ramp    = 0;
        last_ramp = -1;
        done      = 1'b0;
        start     = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == pulse_k) start = 1'b1;
            if (!discharge) begin
                if (first_k < 0) first_k = k;
                n_ramp++;
                last_ramp = int'(ramp_out);
                if (int'(ramp_out) == th0) cv[0] = 1'b0;
                if (int'(ramp_out) == th1) cv[1] = 1'b0;
                if (int'(ramp_out) == th2) cv[2] = 1'b0;
                if (int'(ramp_out) == pulse_ramp) start = 1'b1;
                if (int'(ramp_out) == glitch_ramp) cv[0] = 1'b1;
            end
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("sweep_terminates", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fk, nr, lr, vcnt, rampn, busy_seen;
        logic done;
        string act_seq, exp_seq;

        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        cv         = '1;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_discharge", 32'(discharge), 32'd1);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data", 32'(data), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_ramp", 32'(ramp_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // One-shot sweep: drops at 10/50/200 report 12/52/202.
        cv = '1;
        run_sweep(10, 50, 200, {8'd202, 8'd52, 8'd12}, 3'b000, -1, -1, -1, fk, nr, lr);
        check("t2_first_ramp_latency", 32'(fk), 32'd5);
        check("t2_ramp_cycles", 32'(nr), 32'd203);
        check("t2_last_ramp", 32'(lr), 32'd202);
        check("t2_idle_after", 32'(busy), 32'd0);

        // Over-range on ch2: ramp runs through 255 and stops there.
        cv = '1;
        repeat (2) @(negedge clk);
        run_sweep(5, 100, -1, {8'd255, 8'd102, 8'd7}, 3'b100, -1, -1, -1, fk, nr, lr);
        check("t3_ramp_cycles", 32'(nr), 32'd256);
        check("t3_last_ramp", 32'(lr), 32'd255);

        // Reset held 3 cycles mid-RAMP.
        cv    = '1;
        start = 1'b1;
        done  = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!discharge && ramp_out == 8'd20) begin
                done = 1'b1;
                break;
            end
        end
        check("t1_reached_ramp", 32'(done), 32'd1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_discharge", 32'(discharge), 32'd1);
        check("t1_data", 32'(data), 32'd0);
        check("t1_overflow", 32'(overflow), 32'd0);
        check("t1_valid", 32'(valid), 32'd0);
        @(negedge clk);
        check("t1_still_idle", 32'(busy), 32'd0);

        // All channels already low: captured as 0 on the first RAMP cycle.
        cv = '0;
        repeat (3) @(negedge clk);
        run_sweep(-1, -1, -1, {8'd0, 8'd0, 8'd0}, 3'b000, -1, -1, -1, fk, nr, lr);
        check("t4_first_ramp_latency", 32'(fk), 32'd5);
        check("t4_ramp_cycles", 32'(nr), 32'd1);
        check("t4_last_ramp", 32'(lr), 32'd0);

        // Continuous mode for three sweeps, dropped during the third RAMP.
        for (int i = 0; i < 3; i++) begin
            mon_e.d  = '0;
            mon_e.ov = '0;
            q.push_back(mon_e);
        end
        exp_seq    = "SSSSRDSSSSRDSSSSRDI";
        act_seq    = "";
        vcnt       = 0;
        rampn      = 0;
        continuous = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (valid) vcnt++;
            if (!busy)                                act_seq = {act_seq, "I"};
            else if (valid && discharge)              act_seq = {act_seq, "D"};
            else if (!discharge)                      act_seq = {act_seq, "R"};
            else if (discharge && ramp_out == 8'd0)   act_seq = {act_seq, "S"};
            else                                      act_seq = {act_seq, "?"};
            if (!discharge) begin
                rampn++;
                if (rampn == 3) continuous = 1'b0;
            end
        end
        continuous = 1'b0;
        tests++;
        if (act_seq != exp_seq) begin
            fails++;
            $display("FAIL t5_state_sequence: got %s, expected %s", act_seq, exp_seq);
        end
        check("t5_valid_pulses", 32'(vcnt), 32'd3);
        repeat (4) @(negedge clk);
        check("t5_idle_after", 32'(busy), 32'd0);

        // start pulses during SETTLE and RAMP ignored; ch0 glitch after capture.
        cv = '1;
        repeat (3) @(negedge clk);
        run_sweep(30, 40, 60, {8'd62, 8'd42, 8'd32}, 3'b000, 2, 20, 45, fk, nr, lr);
        check("t6_ramp_cycles", 32'(nr), 32'd63);
        busy_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("t6_no_rearm", 32'(busy_seen), 32'd0);

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
